uart_tx_frame: RTL

//   Parametrised UART transmitter, replacing the fixed 8N1 sender. Serialises one

---
 rtl/uart_tx_frame.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data, optional parity, 1-2 stop bits.
// One word per valid/ready handshake; back-to-back frames are sent with no idle gap.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 dout,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam bit HAS_PARITY = (PARITY_MODE != 0);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_order
    $error("uart_tx_frame: MSB_FIRST must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 dout_q, dout_d;

  logic last_baud, last_stop, accept;

  assign last_baud = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));
  assign done      = (state_q == STOP) && last_baud && last_stop;
  assign tx_ready  = (state_q == IDLE) || done;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state_q != IDLE);
  assign dout      = dout_q;

  // dout_d is the line level for the *next* cycle, so dout_q changes exactly
  // on the edge where the bit period starts.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    dout_d   = dout_q;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        dout_d = 1'b1;
        if (accept) begin
          state_d  = START;
          bit_d    = '0;
          shift_d  = tx_data;
          parity_d = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
          dout_d   = 1'b0;
        end
      end
      START: begin
        if (last_baud) begin
          baud_d  = '0;
          state_d = DATA;
          bit_d   = '0;
          dout_d  = (MSB_FIRST != 0) ? shift_q[DATA_BITS-1] : shift_q[0];
        end
      end
      DATA: begin
        if (last_baud) begin
          baud_d = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (HAS_PARITY) begin
              state_d = PARITY;
              dout_d  = parity_q;
            end else begin
              state_d = STOP;
              dout_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = (MSB_FIRST != 0) ? {shift_q[DATA_BITS-2:0], 1'b0}
                                       : {1'b0, shift_q[DATA_BITS-1:1]};
            dout_d  = (MSB_FIRST != 0) ? shift_d[DATA_BITS-1] : shift_d[0];
          end
        end
      end
      PARITY: begin
        if (last_baud) begin
          baud_d  = '0;
          state_d = STOP;
          bit_d   = '0;
          dout_d  = 1'b1;
        end
      end
      STOP: begin
        dout_d = 1'b1;
        if (last_baud) begin
          baud_d = '0;
          if (!last_stop) begin
            bit_d = bit_q + BIT_W'(1);
          end else if (accept) begin
            // Zero-gap handoff: next frame's start bit follows immediately.
            state_d  = START;
            bit_d    = '0;
            shift_d  = tx_data;
            parity_d = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
            dout_d   = 1'b0;
          end else begin
            state_d = IDLE;
            bit_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        dout_d  = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      dout_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      dout_q   <= dout_d;
    end
  end

endmodule
